// File: rtl/game_sequencer.sv
// Game phase controller: NEWBOARD -> GEN -> MOVE -> CLEAR -> GEN ... -> OVER.
// Owns the gravity timer, the 8-bit piece LFSR and the saturating placed-piece counter.
module game_sequencer #(
  parameter int         DROP_PERIOD  = 50,
  parameter int         FAST_PERIOD  = 5,
  parameter int         GEN_CYCLES   = 2,
  parameter int         CLEAR_CYCLES = 2,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic       clka,
  input  logic       restart_n,
  input  logic       start,
  input  logic       fast_drop,
  input  logic       landed,
  input  logic       error_in,
  output logic [2:0] state,
  output logic [1:0] curr_piece,
  output logic       drop_tick,
  output logic       restart,
  output logic       game_over,
  output logic [7:0] pieces_placed
);

  localparam int CW   = (DROP_PERIOD > 2) ? $clog2(DROP_PERIOD) : 1;
  localparam int PMAX = (GEN_CYCLES > CLEAR_CYCLES) ? GEN_CYCLES : CLEAR_CYCLES;
  localparam int PW   = (PMAX > 2) ? $clog2(PMAX) : 1;

  localparam logic [CW-1:0] DROP_LAST  = CW'(DROP_PERIOD - 1);
  localparam logic [CW-1:0] FAST_LAST  = CW'(FAST_PERIOD - 1);
  localparam logic [PW-1:0] GEN_LAST   = PW'(GEN_CYCLES - 1);
  localparam logic [PW-1:0] CLEAR_LAST = PW'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_GEN      = 3'd0,
    S_MOVE     = 3'd1,
    S_CLEAR    = 3'd2,
    S_OVER     = 3'd3,
    S_NEWBOARD = 3'd4
  } phase_t;

  phase_t        state_reg;
  logic [7:0]    lfsr_reg;
  logic          start_q_reg;
  logic [CW-1:0] drop_cnt_reg;
  logic [PW-1:0] phase_cnt_reg;
  logic [1:0]    piece_reg;
  logic          tick_reg;
  logic          restart_reg;
  logic          over_reg;
  logic [7:0]    placed_reg;

  logic          lfsr_fb;
  logic          start_rise;
  logic [CW-1:0] period_last;

  // x^8+x^6+x^5+x^4+1: taps at bits 7,5,4,3 of a left-shifting register
  assign lfsr_fb     = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
  assign start_rise  = start & ~start_q_reg;
  assign period_last = fast_drop ? FAST_LAST : DROP_LAST;

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_reg     <= S_NEWBOARD;
      lfsr_reg      <= LFSR_SEED;
      start_q_reg   <= 1'b0;
      drop_cnt_reg  <= '0;
      phase_cnt_reg <= '0;
      piece_reg     <= 2'd0;
      tick_reg      <= 1'b0;
      restart_reg   <= 1'b1;
      over_reg      <= 1'b0;
      placed_reg    <= 8'd0;
    end else begin
      lfsr_reg    <= {lfsr_reg[6:0], lfsr_fb};
      start_q_reg <= start;
      tick_reg    <= 1'b0;
      case (state_reg)
        S_NEWBOARD: begin
          restart_reg <= 1'b1;
          if (start_rise) begin
            state_reg     <= S_GEN;
            piece_reg     <= lfsr_reg[1:0];
            placed_reg    <= 8'd0;
            restart_reg   <= 1'b0;
            phase_cnt_reg <= '0;
          end
        end
        S_GEN: begin
          if (phase_cnt_reg == GEN_LAST) begin
            if (error_in) begin
              state_reg <= S_OVER;
              over_reg  <= 1'b1;
            end else begin
              state_reg    <= S_MOVE;
              drop_cnt_reg <= '0;
            end
          end else begin
            phase_cnt_reg <= phase_cnt_reg + PW'(1);
          end
        end
        S_MOVE: begin
          // landed only counts while the gravity pulse is visible downstream
          if (tick_reg && landed) begin
            state_reg     <= S_CLEAR;
            phase_cnt_reg <= '0;
            if (placed_reg != 8'hFF) placed_reg <= placed_reg + 8'd1;
          end else if (drop_cnt_reg >= period_last) begin
            tick_reg     <= 1'b1;
            drop_cnt_reg <= '0;
          end else begin
            drop_cnt_reg <= drop_cnt_reg + CW'(1);
          end
        end
        S_CLEAR: begin
          if (phase_cnt_reg == CLEAR_LAST) begin
            state_reg     <= S_GEN;
            piece_reg     <= lfsr_reg[1:0];
            phase_cnt_reg <= '0;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + PW'(1);
          end
        end
        S_OVER: begin
          over_reg <= 1'b1;
          if (start_rise) begin
            state_reg   <= S_NEWBOARD;
            restart_reg <= 1'b1;
            over_reg    <= 1'b0;
          end
        end
        default: state_reg <= S_NEWBOARD;
      endcase
    end
  end

  assign state         = state_reg;
  assign curr_piece    = piece_reg;
  assign drop_tick     = tick_reg;
  assign restart       = restart_reg;
  assign game_over     = over_reg;
  assign pieces_placed = placed_reg;

endmodule
